// File: rtl/plot_arbiter_if.sv
// Shared VGA write port bundle: two box-plot requesters on one side, the
// adapter pixel port and status on the other.
interface plot_arbiter_if;
   logic       hold;
   logic       p_req;
   logic [7:0] p_x;
   logic [6:0] p_y;
   logic [2:0] p_colour;
   logic       c_req;
   logic [7:0] c_x;
   logic [6:0] c_y;
   logic [2:0] c_colour;
   logic       p_ack;
   logic       c_ack;
   logic       busy;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   modport slave (
      input  hold, p_req, p_x, p_y, p_colour, c_req, c_x, c_y, c_colour,
      output p_ack, c_ack, busy, vga_x, vga_y, vga_colour, vga_plot
   );

   modport master (
      output hold, p_req, p_x, p_y, p_colour, c_req, c_x, c_y, c_colour,
      input  p_ack, c_ack, busy, vga_x, vga_y, vga_colour, vga_plot
   );
endinterface

// File: rtl/plot_arbiter.sv
// Round-robin arbiter between the player and CPU box plotters; rasterises the
// granted box into single-pixel writes on the VGA adapter port.
module plot_arbiter #(
   parameter int unsigned BOX_W = 4,
   parameter int unsigned BOX_H = 2
) (
   input  logic           clk,
   input  logic           resetn,
   plot_arbiter_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DRAW = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic ID_P = 1'b0;
   localparam logic ID_C = 1'b1;

   localparam logic [2:0] DX_LAST = 3'(BOX_W - 1);
   localparam logic [2:0] DY_LAST = 3'(BOX_H - 1);

   logic [1:0] state_q, state_d;
   logic [2:0] dx_q, dx_d;
   logic [2:0] dy_q, dy_d;
   logic [7:0] bx_q, bx_d;
   logic [6:0] by_q, by_d;
   logic [2:0] col_q, col_d;
   logic       gid_q, gid_d;
   logic       last_q, last_d;
   logic [7:0] vx_q, vx_d;
   logic [6:0] vy_q, vy_d;
   logic [2:0] vc_q, vc_d;
   logic       plot_q, plot_d;
   logic       gnt_c;

   // Next-state, latch and pixel-output computation
   always_comb begin
      state_d = state_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      bx_d    = bx_q;
      by_d    = by_q;
      col_d   = col_q;
      gid_d   = gid_q;
      last_d  = last_q;
      vx_d    = vx_q;
      vy_d    = vy_q;
      vc_d    = vc_q;
      plot_d  = 1'b0;
      gnt_c   = ID_P;

      case (state_q)
         S_IDLE: begin
            if (!bus.hold && (bus.p_req || bus.c_req)) begin
               // On a tie the requester that did not go last wins
               if (bus.p_req && bus.c_req) begin
                  gnt_c = ~last_q;
               end else begin
                  gnt_c = bus.c_req ? ID_C : ID_P;
               end
               gid_d   = gnt_c;
               bx_d    = (gnt_c == ID_C) ? bus.c_x      : bus.p_x;
               by_d    = (gnt_c == ID_C) ? bus.c_y      : bus.p_y;
               col_d   = (gnt_c == ID_C) ? bus.c_colour : bus.p_colour;
               dx_d    = 3'd0;
               dy_d    = 3'd0;
               vx_d    = bx_d;
               vy_d    = by_d;
               vc_d    = col_d;
               plot_d  = 1'b1;
               state_d = S_DRAW;
            end
         end

         S_DRAW: begin
            if (dx_q == DX_LAST && dy_q == DY_LAST) begin
               state_d = S_DONE;
            end else begin
               if (dx_q == DX_LAST) begin
                  dx_d = 3'd0;
                  dy_d = dy_q + 3'd1;
               end else begin
                  dx_d = dx_q + 3'd1;
               end
               // Sums wrap naturally at the port width
               vx_d   = bx_q + 8'(dx_d);
               vy_d   = by_q + 7'(dy_d);
               vc_d   = col_q;
               plot_d = 1'b1;
            end
         end

         S_DONE: begin
            last_d  = gid_q;
            dx_d    = 3'd0;
            dy_d    = 3'd0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         dx_q    <= 3'd0;
         dy_q    <= 3'd0;
         bx_q    <= 8'd0;
         by_q    <= 7'd0;
         col_q   <= 3'd0;
         gid_q   <= ID_P;
         last_q  <= ID_C;
         vx_q    <= 8'd0;
         vy_q    <= 7'd0;
         vc_q    <= 3'd0;
         plot_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         col_q   <= col_d;
         gid_q   <= gid_d;
         last_q  <= last_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         vc_q    <= vc_d;
         plot_q  <= plot_d;
      end
   end

   // Acks and busy decode straight from registered state
   assign bus.p_ack      = (state_q == S_DONE) && (gid_q == ID_P);
   assign bus.c_ack      = (state_q == S_DONE) && (gid_q == ID_C);
   assign bus.busy       = (state_q == S_DRAW) || (state_q == S_DONE);
   assign bus.vga_x      = vx_q;
   assign bus.vga_y      = vy_q;
   assign bus.vga_colour = vc_q;
   assign bus.vga_plot   = plot_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Bench for plot_arbiter: directed scenarios plus randomized traffic checked
// against a box-level model of grants, raster order and acks.
module tb_plot_arbiter;

   localparam int unsigned BOX_W = 4;
   localparam int unsigned BOX_H = 2;

   logic clk;
   logic resetn;
   int   total = 0;
   int   bad   = 0;

   int         m_last;
   logic [7:0] m_vx;
   logic [6:0] m_vy;
   logic [2:0] m_vc;

   plot_arbiter_if bus();

   plot_arbiter #(.BOX_W(BOX_W), .BOX_H(BOX_H)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [21:0] obs();
      return {bus.vga_plot, bus.busy, bus.p_ack, bus.c_ack, bus.vga_x, bus.vga_y, bus.vga_colour};
   endfunction

   function automatic logic [21:0] pack(input logic pl, input logic bs, input logic pa,
                                        input logic ca, input logic [7:0] x,
                                        input logic [6:0] y, input logic [2:0] c);
      return {pl, bs, pa, ca, x, y, c};
   endfunction

   // One granted box: grant edge, BOX_W*BOX_H pixels, ack cycle, then back in IDLE
   task automatic expect_box(input int id, input int x0, input int y0, input int c0,
                             input int hold_pix, input bit scramble, input string name);
      logic [21:0] e;
      for (int i = 0; i < int'(BOX_W * BOX_H); i++) begin
         @(posedge clk); #1;
         m_vx = 8'((x0 + i % int'(BOX_W)) % 256);
         m_vy = 7'((y0 + i / int'(BOX_W)) % 128);
         m_vc = 3'(c0);
         e = pack(1'b1, 1'b1, 1'b0, 1'b0, m_vx, m_vy, m_vc);
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL %s pix%0d: got %h exp %h", name, i, obs(), e);
         end
         if (i == hold_pix) begin
            bus.hold  = 1'b1;
            bus.p_req = 1'b1;
         end
         if (scramble) begin
            bus.p_x = 8'($urandom); bus.p_y = 7'($urandom); bus.p_colour = 3'($urandom);
            bus.c_x = 8'($urandom); bus.c_y = 7'($urandom); bus.c_colour = 3'($urandom);
            bus.hold = 1'($urandom);
         end
      end
      @(posedge clk); #1;
      e = pack(1'b0, 1'b1, id == 0, id == 1, m_vx, m_vy, m_vc);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL %s ack: got %h exp %h", name, obs(), e);
      end
      m_last = id;
      @(posedge clk); #1;
      e = pack(1'b0, 1'b0, 1'b0, 1'b0, m_vx, m_vy, m_vc);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL %s idle: got %h exp %h", name, obs(), e);
      end
   endtask

   task automatic idle_cycle(input string name);
      logic [21:0] e;
      @(posedge clk); #1;
      e = pack(1'b0, 1'b0, 1'b0, 1'b0, m_vx, m_vy, m_vc);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL %s: got %h exp %h", name, obs(), e);
      end
   endtask

   task automatic set_p(input int x, input int y, input int c);
      bus.p_x = 8'(x); bus.p_y = 7'(y); bus.p_colour = 3'(c);
   endtask

   task automatic set_c(input int x, input int y, input int c);
      bus.c_x = 8'(x); bus.c_y = 7'(y); bus.c_colour = 3'(c);
   endtask

   task automatic test_reset();
      logic [21:0] e;
      resetn = 1'b0;
      bus.p_req = 1'b0; bus.c_req = 1'b0; bus.hold = 1'b0;
      @(posedge clk); #1;
      e = 22'd0;
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL reset: got %h exp %h", obs(), e);
      end
      m_last = 1; m_vx = 8'd0; m_vy = 7'd0; m_vc = 3'd0;
      resetn = 1'b1;
   endtask

   task automatic test_basic();
      set_p(118, 100, 4);
      bus.p_req = 1'b1;
      expect_box(0, 118, 100, 4, -1, 1'b0, "basic");
      bus.p_req = 1'b0;
      idle_cycle("basic_quiet");
   endtask

   task automatic test_wrap();
      set_c(254, 127, 1);
      bus.c_req = 1'b1;
      expect_box(1, 254, 127, 1, -1, 1'b0, "wrap");
      bus.c_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      test_reset();
      set_p(118, 97, 2);
      set_c(123, 100, 1);
      bus.p_req = 1'b1; bus.c_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) expect_box(0, 118, 97, 2, -1, 1'b0, "b2b_p");
         else            expect_box(1, 123, 100, 1, -1, 1'b0, "b2b_c");
      end
      bus.p_req = 1'b0; bus.c_req = 1'b0;
   endtask

   task automatic test_hold();
      set_p(118, 97, 2);
      set_c(123, 100, 1);
      bus.c_req = 1'b1;
      expect_box(1, 123, 100, 1, 2, 1'b0, "hold_c");
      bus.c_req = 1'b0;
      for (int k = 0; k < 3; k++) idle_cycle("hold_block");
      bus.hold = 1'b0;
      expect_box(0, 118, 97, 2, -1, 1'b0, "hold_p");
      bus.p_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [21:0] e;
      set_p(118, 100, 4);
      bus.p_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         e = pack(1'b1, 1'b1, 1'b0, 1'b0, 8'(118 + i % int'(BOX_W)),
                  7'(100 + i / int'(BOX_W)), 3'd4);
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL midrst pix%0d: got %h exp %h", i, obs(), e);
         end
      end
      resetn = 1'b0;
      bus.p_req = 1'b0;
      @(posedge clk); #1;
      e = 22'd0;
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL midrst abort: got %h exp %h", obs(), e);
      end
      resetn = 1'b1;
      m_last = 1; m_vx = 8'd0; m_vy = 7'd0; m_vc = 3'd0;
      set_c(123, 100, 1);
      bus.p_req = 1'b1; bus.c_req = 1'b1;
      expect_box(0, 118, 100, 4, -1, 1'b0, "midrst_tie");
      bus.p_req = 1'b0; bus.c_req = 1'b0;
   endtask

   task automatic test_stability();
      set_c(123, 60, 5);
      bus.c_req = 1'b1;
      expect_box(1, 123, 60, 5, -1, 1'b1, "stable");
      bus.c_req = 1'b0;
      bus.hold  = 1'b0;
   endtask

   task automatic test_random();
      int win;
      for (int it = 0; it < 200; it++) begin
         bus.p_req = 1'($urandom_range(0, 1));
         bus.c_req = 1'($urandom_range(0, 1));
         bus.hold  = ($urandom_range(0, 3) == 0);
         set_p(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
         set_c(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
         if (!bus.hold && (bus.p_req || bus.c_req)) begin
            if (bus.p_req && bus.c_req) win = (m_last == 1) ? 0 : 1;
            else                        win = bus.p_req ? 0 : 1;
            if (win == 0)
               expect_box(0, int'(bus.p_x), int'(bus.p_y), int'(bus.p_colour), -1, 1'b1, "rand_p");
            else
               expect_box(1, int'(bus.c_x), int'(bus.c_y), int'(bus.c_colour), -1, 1'b1, "rand_c");
         end else begin
            idle_cycle("rand_idle");
         end
      end
      bus.p_req = 1'b0; bus.c_req = 1'b0; bus.hold = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      bus.hold = 1'b0; bus.p_req = 1'b0; bus.c_req = 1'b0;
      set_p(0, 0, 0);
      set_c(0, 0, 0);
      test_reset();
      test_basic();
      test_wrap();
      test_back_to_back();
      test_hold();
      test_reset_mid();
      test_stability();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
